apb_timer_slave: RTL and testbench

- APB slave peripheral downstream of the AHB-to-APB bridge; one instance hangs off one bit of the bridge's 3-bit psel bus.
- Provides a programmable 32-bit down-counter with an 8-bit prescaler, optional auto-reload, a sticky expiry flag and a level interrupt.
- Read data returns on prdata to the bridge and is zero when the instance is not selected, so several slaves' prdata can be OR-combined at top level.

---
 rtl/apb_timer_slave.sv | 146 ++++++++++++++
 tb/tb_apb_timer_slave.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_slave.sv
// APB timer slave: 32-bit down-counter with 8-bit prescaler, auto-reload,
// sticky expiry flag and level interrupt. prdata is zero whenever unselected.
module apb_timer_slave #(
  parameter int unsigned PSEL_BIT = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [2:0]  psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    REG_CTRL   = 2'b00,
    REG_LOAD   = 2'b01,
    REG_COUNT  = 2'b10,
    REG_STATUS = 2'b11
  } reg_addr_e;

  logic        sel;
  logic        wr_commit;
  logic        rd_setup;
  reg_addr_e   addr;
  logic        tick;
  logic        expire;
  logic [31:0] rdata;
  logic        unused_ok;

  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        irq_en_q, irq_en_d;
  logic [7:0]  presc_q, presc_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        expired_q, expired_d;
  logic [7:0]  presc_cnt_q, presc_cnt_d;
  logic [31:0] prdata_q, prdata_d;

  assign sel       = psel[PSEL_BIT];
  assign wr_commit = sel & penable & pwrite;
  assign rd_setup  = sel & ~penable & ~pwrite;
  assign addr      = reg_addr_e'(paddr[3:2]);
  assign unused_ok = ^{psel, paddr[31:4], paddr[1:0]};

  always_comb begin
    unique case (addr)
      REG_CTRL:   rdata = {16'h0000, presc_q, 5'b00000, irq_en_q, auto_q, en_q};
      REG_LOAD:   rdata = load_q;
      REG_COUNT:  rdata = count_q;
      REG_STATUS: rdata = {31'h0000_0000, expired_q};
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    en_d        = en_q;
    auto_d      = auto_q;
    irq_en_d    = irq_en_q;
    presc_d     = presc_q;
    load_d      = load_q;
    count_d     = count_q;
    expired_d   = expired_q;
    presc_cnt_d = '0;
    prdata_d    = prdata_q;
    expire      = 1'b0;

    tick = en_q && (presc_cnt_q == presc_q);
    if (en_q && !tick) begin
      presc_cnt_d = presc_cnt_q + 8'd1;
    end

    if (tick) begin
      if (count_q > 32'd1) begin
        count_d = count_q - 32'd1;
      end else if (count_q == 32'd1) begin
        expire  = 1'b1;
        count_d = auto_q ? load_q : '0;
      end
    end

    // A LOAD write overrides any same-cycle tick, including its expiry.
    if (wr_commit) begin
      unique case (addr)
        REG_CTRL: begin
          en_d     = pwdata[0];
          auto_d   = pwdata[1];
          irq_en_d = pwdata[2];
          presc_d  = pwdata[15:8];
        end
        REG_LOAD: begin
          load_d  = pwdata;
          count_d = pwdata;
          expire  = 1'b0;
        end
        REG_STATUS: begin
          if (pwdata[0]) begin
            expired_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (expire) begin
      expired_d = 1'b1;
    end

    if (!sel) begin
      prdata_d = '0;
    end else if (rd_setup) begin
      prdata_d = rdata;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      en_q        <= 1'b0;
      auto_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      presc_q     <= '0;
      load_q      <= '0;
      count_q     <= '0;
      expired_q   <= 1'b0;
      presc_cnt_q <= '0;
      prdata_q    <= '0;
    end else begin
      en_q        <= en_d;
      auto_q      <= auto_d;
      irq_en_q    <= irq_en_d;
      presc_q     <= presc_d;
      load_q      <= load_d;
      count_q     <= count_d;
      expired_q   <= expired_d;
      presc_cnt_q <= presc_cnt_d;
      prdata_q    <= prdata_d;
    end
  end

  assign prdata = prdata_q;
  assign irq    = expired_q & irq_en_q;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave (instance on psel[1]).
module tb_apb_timer_slave;

  logic        hclk;
  logic        hresetn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        irq;

  int total;
  int bad;
  logic [31:0] rd;

  localparam logic [2:0] SEL = 3'b010;

  apb_timer_slave #(.PSEL_BIT(1)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .irq     (irq)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task step(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  // Commit edge is the third rising edge after the call; returns 1 time unit later.
  task apb_write(input logic [2:0] ps, input logic [31:0] addr, input logic [31:0] data);
    @(posedge hclk); #1;
    psel = ps; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(posedge hclk); #1;
    psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
  endtask

  task apb_read(input logic [2:0] ps, input logic [31:0] addr, output logic [31:0] data);
    @(posedge hclk); #1;
    psel = ps; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(posedge hclk); #1;
    penable = 1'b1;
    data = prdata;
    @(posedge hclk); #1;
    psel = 3'b000; penable = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    hresetn = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    step(3);
    check("rst_prdata", prdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    hresetn = 1'b1;
    step(2);

    // 1. Register access
    apb_write(SEL, 32'h0, 32'h0000_0306);
    apb_write(SEL, 32'h4, 32'h1234_5678);
    apb_read(SEL, 32'h0, rd);  check("t1_ctrl", rd, 32'h0000_0306);
    step(1);                   check("t1_prdata_idle", prdata, 32'h0);
    apb_read(SEL, 32'h4, rd);  check("t1_load", rd, 32'h1234_5678);
    apb_read(SEL, 32'h8, rd);  check("t1_count", rd, 32'h1234_5678);
    apb_write(SEL, 32'h8, 32'hFFFF_FFFF);
    apb_read(SEL, 32'h8, rd);  check("t1_count_ro", rd, 32'h1234_5678);
    apb_write(SEL, 32'h0, 32'hFFFF_FFF8);
    apb_read(SEL, 32'h0, rd);  check("t1_ctrl_mask", rd, 32'h0000_FF00);
    apb_read(SEL, 32'hC, rd);  check("t1_status", rd, 32'h0);

    // 2. Basic countdown, PRESC=0
    apb_write(SEL, 32'h4, 32'd5);
    apb_write(SEL, 32'h0, 32'h0000_0005);
    check("t2_count_e0", dut.count_q, 32'd5);
    step(4);
    check("t2_count_e4", dut.count_q, 32'd1);
    check("t2_irq_e4", {31'h0, irq}, 32'h0);
    step(1);
    check("t2_count_e5", dut.count_q, 32'd0);
    check("t2_irq_e5", {31'h0, irq}, 32'h1);
    step(3);
    check("t2_count_hold", dut.count_q, 32'd0);
    check("t2_irq_hold", {31'h0, irq}, 32'h1);
    apb_write(SEL, 32'hC, 32'h0);
    check("t2_w0_noclr", {31'h0, irq}, 32'h1);
    apb_read(SEL, 32'hC, rd);  check("t2_status", rd, 32'h1);
    apb_write(SEL, 32'hC, 32'h1);
    check("t2_w1c", {31'h0, irq}, 32'h0);
    apb_write(SEL, 32'h0, 32'h0);

    // 3. Prescale 3 with auto-reload, no IRQ_EN
    apb_write(SEL, 32'h4, 32'd3);
    apb_write(SEL, 32'h0, 32'h0000_0303);
    for (int k = 1; k <= 24; k++) begin
      step(1);
      check("t3_count", dut.count_q, 32'(3 - ((k / 4) % 3)));
      check("t3_irq", {31'h0, irq}, 32'h0);
      if (k == 11) check("t3_exp_k11", {31'h0, dut.expired_q}, 32'h0);
      if (k == 12) check("t3_exp_k12", {31'h0, dut.expired_q}, 32'h1);
    end

    // 4. Collisions: W1C lands on the expiry edge (E36), then a plain clear (E39)
    step(9);
    apb_write(SEL, 32'hC, 32'h1);
    check("t4_w1c_vs_set", {31'h0, dut.expired_q}, 32'h1);
    check("t4_reload", dut.count_q, 32'd3);
    apb_write(SEL, 32'hC, 32'h1);
    check("t4_w1c_plain", {31'h0, dut.expired_q}, 32'h0);
    // LOAD write on the tick edge where COUNT==1 (E48)
    step(6);
    apb_write(SEL, 32'h4, 32'd9);
    check("t4_load_wins", dut.count_q, 32'd9);
    check("t4_no_expiry", {31'h0, dut.expired_q}, 32'h0);
    step(4);
    check("t4_next_tick", dut.count_q, 32'd8);
    apb_write(SEL, 32'h0, 32'h0);

    // 5. Select isolation
    apb_write(SEL, 32'h4, 32'h0000_0011);
    apb_write(3'b001, 32'h4, 32'h0000_DEAD);
    apb_write(3'b100, 32'h0, 32'h0000_0007);
    apb_read(3'b100, 32'h4, rd);  check("t5_prdata_unsel", rd, 32'h0);
    apb_read(3'b001, 32'h0, rd);  check("t5_prdata_unsel2", rd, 32'h0);
    apb_read(SEL, 32'h4, rd);     check("t5_load_kept", rd, 32'h0000_0011);
    apb_read(SEL, 32'h0, rd);     check("t5_ctrl_kept", rd, 32'h0);
    apb_write(SEL, 32'h4, 32'h0000_BEEF);
    apb_read(SEL, 32'h4, rd);     check("t5_load_sel", rd, 32'h0000_BEEF);

    // 6. Reset during a write access phase
    apb_write(SEL, 32'h4, 32'd1);
    apb_write(SEL, 32'h0, 32'h0000_0005);
    step(2);
    apb_write(SEL, 32'h0, 32'h0000_FF05);
    apb_write(SEL, 32'h4, 32'h0000_0020);
    check("t6_pre_count", dut.count_q, 32'h20);
    @(posedge hclk); #1;
    psel = SEL; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h0000_0055;
    @(posedge hclk); #1;
    penable = 1'b1;
    check("t6_pre_irq", {31'h0, irq}, 32'h1);
    #2 hresetn = 1'b0;
    #1;
    check("t6_rst_irq", {31'h0, irq}, 32'h0);
    check("t6_rst_prdata", prdata, 32'h0);
    check("t6_rst_count", dut.count_q, 32'h0);
    @(posedge hclk); #1;
    psel = '0; penable = 1'b0; pwrite = 1'b0;
    @(negedge hclk);
    hresetn = 1'b1;
    apb_read(SEL, 32'h0, rd);  check("t6_ctrl", rd, 32'h0);
    apb_read(SEL, 32'h4, rd);  check("t6_load", rd, 32'h0);
    apb_read(SEL, 32'h8, rd);  check("t6_count", rd, 32'h0);
    apb_read(SEL, 32'hC, rd);  check("t6_status", rd, 32'h0);
    step(10);
    apb_read(SEL, 32'h8, rd);  check("t6_count_idle", rd, 32'h0);
    check("t6_irq_idle", {31'h0, irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
